// File: rtl/hamming_pkg.sv
// Shared types and word-layout constants for the Hamming(16,11) DMA engine.
// Holds the FSM state enum, decode flag codes and codeword bit positions.
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAPT,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

    localparam logic [1:0] FLG_OK  = 2'b00;
    localparam logic [1:0] FLG_SEC = 2'b01;
    localparam logic [1:0] FLG_DED = 2'b10;

    // Codeword bit k is Hamming position k; bit 0 carries overall parity.
    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;
    localparam int POS_P8 = 8;

    // Codeword positions of data bits d1..d11 (entry 0 is d1).
    localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic logic [3:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) begin
                s = s ^ k[3:0];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming_codec.sv
// Combinational Hamming(16,11) SECDED codec: encodes an 11-bit message or
// decodes/corrects a 16-bit codeword depending on mode_i.
module hamming_codec
    import hamming_pkg::*;
(
    input  logic        mode_i,
    input  logic [15:0] word_i,
    output logic [15:0] word_o,
    output logic [1:0]  flags_o
);

    logic [10:0] srcData;
    logic [15:0] encWord;
    logic [3:0]  encSyn;
    logic [3:0]  decSyn;
    logic        decPar;
    logic [15:0] fixWord;
    logic [10:0] decData;
    logic [1:0]  decFlags;

    // Encoder: parity bits are chosen so the syndrome of the codeword is zero.
    always_comb begin
        srcData = word_i[10:0];
        encWord = '0;
        for (int i = 0; i < 11; i++) begin
            encWord[DATA_POS[i]] = srcData[i];
        end
        encSyn          = syndrome(encWord);
        encWord[POS_P1] = encSyn[0];
        encWord[POS_P2] = encSyn[1];
        encWord[POS_P4] = encSyn[2];
        encWord[POS_P8] = encSyn[3];
        encWord[POS_P0] = ^encWord[15:1];
    end

    // Decoder: odd overall parity means a single flip at the syndrome position.
    always_comb begin
        decSyn   = syndrome(word_i);
        decPar   = ^word_i;
        fixWord  = word_i;
        decFlags = FLG_OK;
        if (decPar) begin
            decFlags        = FLG_SEC;
            fixWord[decSyn] = ~word_i[decSyn];
        end else if (decSyn != 4'd0) begin
            decFlags = FLG_DED;
        end
        for (int i = 0; i < 11; i++) begin
            decData[i] = fixWord[DATA_POS[i]];
        end
    end

    always_comb begin
        word_o  = encWord;
        flags_o = FLG_OK;
        if (mode_i) begin
            word_o  = {decFlags, 3'b000, decData};
            flags_o = decFlags;
        end
    end

endmodule

// File: rtl/hamming_dma.sv
// DMA engine that streams MSG_COUNT words through the Hamming codec in memory.
// Define HAMMING_DMA_STATUS_EN to build the corrected/detected error counters.
module hamming_dma
    import hamming_pkg::*;
#(
    parameter int MSG_COUNT = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sec_count,
    output logic [7:0]        ded_count
);

    localparam logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] HI_OFS   = ADDR_W'(1);
    localparam logic [6:0]        LAST_IDX = 7'(MSG_COUNT - 1);

    state_e            state_q, state_d;
    logic [6:0]        index_q, index_d;
    logic              mode_q, mode_d;
    logic [7:0]        loByte_q, loByte_d;
    logic [15:0]       captWord_q, captWord_d;
    logic [ADDR_W-1:0] wordOffset;
    logic              startRun;
    logic [15:0]       codecWord;
    logic [1:0]        codecFlags;

    hamming_codec u_codec (
        .mode_i  (mode_q),
        .word_i  (captWord_q),
        .word_o  (codecWord),
        .flags_o (codecFlags)
    );

    assign wordOffset = ADDR_W'({index_q, 1'b0});
    assign startRun   = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            mode_q     <= 1'b0;
            loByte_q   <= '0;
            captWord_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            mode_q     <= mode_d;
            loByte_q   <= loByte_d;
            captWord_q <= captWord_d;
        end
    end

    // Read data lags the address by a cycle, so each byte lands one state later.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        mode_d      = mode_q;
        loByte_d    = loByte_q;
        captWord_d  = captWord_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                busy = 1'b0;
                done = (state_q == DONE);
                if (startRun) begin
                    mode_d  = mode;
                    index_d = '0;
                    state_d = (MSG_COUNT == 0) ? DONE : RD_LO;
                end
            end
            RD_LO: begin
                mem_addr = SRC_ADDR + wordOffset;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = SRC_ADDR + wordOffset + HI_OFS;
                loByte_d = mem_rd_data;
                state_d  = CAPT;
            end
            CAPT: begin
                captWord_d = {mem_rd_data, loByte_q};
                state_d    = WR_LO;
            end
            WR_LO: begin
                mem_addr    = DST_ADDR + wordOffset;
                mem_wr_en   = 1'b1;
                mem_wr_data = codecWord[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_addr    = DST_ADDR + wordOffset + HI_OFS;
                mem_wr_en   = 1'b1;
                mem_wr_data = codecWord[15:8];
                if (index_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 7'd1;
                    state_d = RD_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HAMMING_DMA_STATUS_EN
    logic [7:0] secCount_q, secCount_d;
    logic [7:0] dedCount_q, dedCount_d;

    // Each message is tallied once, in WR_LO; encode runs always report FLG_OK.
    always_comb begin
        secCount_d = secCount_q;
        dedCount_d = dedCount_q;
        if (startRun) begin
            secCount_d = '0;
            dedCount_d = '0;
        end else if (state_q == WR_LO) begin
            if (codecFlags == FLG_SEC && secCount_q != 8'hFF) begin
                secCount_d = secCount_q + 8'd1;
            end
            if (codecFlags == FLG_DED && dedCount_q != 8'hFF) begin
                dedCount_d = dedCount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            secCount_q <= '0;
            dedCount_q <= '0;
        end else begin
            secCount_q <= secCount_d;
            dedCount_q <= dedCount_d;
        end
    end

    assign sec_count = secCount_q;
    assign ded_count = dedCount_q;
`else
    logic unusedFlags;
    assign unusedFlags = ^codecFlags;
    assign sec_count   = '0;
    assign ded_count   = '0;
`endif

endmodule

// File: tb/tb_hamming_dma.sv
// Directed testbench for hamming_dma: encode, decode, busy-start, mid-run
// reset and the empty-run configuration, against hand-computed codewords.
module tb_hamming_dma;

    localparam int SRC      = 0;
    localparam int DST      = 30;
    localparam int N        = 15;
    localparam int RUN_CYC  = 5 * N + 1;

    // Source words are {hi, lo}; expected results are {hi, lo} of the destination.
    localparam logic [15:0] ENC_SRC [15] = '{16'h07FF, 16'h0000, 16'h0001, 16'h0400, 16'h0080,
                                             16'hF800, 16'hFFFF, 16'h0002, 16'h0100, 16'h0000,
                                             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [15:0] ENC_EXP [15] = '{16'hFFFF, 16'h0000, 16'h000F, 16'h8117, 16'h1111,
                                             16'h0000, 16'hFFFF, 16'h0033, 16'h2112, 16'h0000,
                                             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [15:0] DEC_SRC [15] = '{16'hFFF7, 16'hFFF3, 16'hFFFE, 16'hFFFF, 16'h0000,
                                             16'h8117, 16'hA117, 16'h1111, 16'h0003, 16'h0001,
                                             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [15:0] DEC_EXP [15] = '{16'h47FF, 16'h87FE, 16'h47FF, 16'h07FF, 16'h0000,
                                             16'h0400, 16'h4400, 16'h0080, 16'h8000, 16'h4000,
                                             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`ifdef HAMMING_DMA_STATUS_EN
    localparam logic [7:0] EXP_SEC = 8'd4;
    localparam logic [7:0] EXP_DED = 8'd2;
`else
    localparam logic [7:0] EXP_SEC = 8'd0;
    localparam logic [7:0] EXP_DED = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, mode, start0;
    logic [7:0] memAddr, memRdData, memWrData, secCount, dedCount;
    logic       memWrEn, busy, done;
    logic [7:0] memAddr0, memRdData0, memWrData0, secCount0, dedCount0;
    logic       memWrEn0, busy0, done0;

    logic [7:0] mem [0:255];
    logic       loadEn;
    logic [7:0] loadAddr, loadData;
    int         wrCount = 0;
    int         wrCount0 = 0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    hamming_dma #(.MSG_COUNT(N), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .mem_addr(memAddr), .mem_rd_data(memRdData), .mem_wr_en(memWrEn),
        .mem_wr_data(memWrData), .busy(busy), .done(done),
        .sec_count(secCount), .ded_count(dedCount)
    );

    hamming_dma #(.MSG_COUNT(0), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)) dutZero (
        .clk(clk), .reset(reset), .start(start0), .mode(mode),
        .mem_addr(memAddr0), .mem_rd_data(memRdData0), .mem_wr_en(memWrEn0),
        .mem_wr_data(memWrData0), .busy(busy0), .done(done0),
        .sec_count(secCount0), .ded_count(dedCount0)
    );

    assign memRdData0 = 8'h00;

    // Byte memory with one-cycle read latency and a backdoor load port.
    always @(posedge clk) begin
        if (loadEn) mem[loadAddr] <= loadData;
        else if (memWrEn) mem[memAddr] <= memWrData;
        memRdData <= mem[memAddr];
    end

    always @(posedge clk) begin
        if (memWrEn) wrCount <= wrCount + 1;
        if (memWrEn0) wrCount0 <= wrCount0 + 1;
    end

    task automatic loadByte(input int a, input logic [7:0] d);
        loadAddr = 8'(a);
        loadData = d;
        loadEn   = 1'b1;
        @(posedge clk); #1;
        loadEn   = 1'b0;
    endtask

    task automatic loadTable(input logic encodeSet);
        for (int i = 0; i < N; i++) begin
            logic [15:0] w;
            w = encodeSet ? ENC_SRC[i] : DEC_SRC[i];
            loadByte(SRC + 2 * i, w[7:0]);
            loadByte(SRC + 2 * i + 1, w[15:8]);
        end
    endtask

    task automatic runToDone(input logic m, input int pulseAt, output int cycles, output int busyLow);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start   = 1'b0;
        mode    = ~m;
        cycles  = 1;
        busyLow = 0;
        while (done !== 1'b1 && cycles < 400) begin
            if (busy !== 1'b1) busyLow++;
            if (cycles == pulseAt) begin
                start = 1'b1;
                mode  = ~m;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared += 9;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        if (memWrEn !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_en: got %b want 0", memWrEn); end
        if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_addr: got %h want 00", memAddr); end
        if (memWrData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_wr_data: got %h want 00", memWrData); end
        if (secCount !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_sec: got %h want 00", secCount); end
        if (dedCount !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_ded: got %h want 00", dedCount); end
        if (busy0 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy0: got %b want 0", busy0); end
        if (done0 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done0: got %b want 0", done0); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_encode;
        int cycles, busyLow, wrStart;
        loadTable(1'b1);
        wrStart = wrCount;
        runToDone(1'b0, 0, cycles, busyLow);
        compared += 4;
        if (cycles != RUN_CYC) begin mismatched++; $display("[TB] FAIL enc_latency: got %0d want %0d", cycles, RUN_CYC); end
        if (busyLow != 0) begin mismatched++; $display("[TB] FAIL enc_busy: got %0d idle cycles want 0", busyLow); end
        if (wrCount - wrStart != 2 * N) begin mismatched++; $display("[TB] FAIL enc_writes: got %0d want %0d", wrCount - wrStart, 2 * N); end
        if (secCount !== 8'h00 || dedCount !== 8'h00) begin
            mismatched++; $display("[TB] FAIL enc_counters: got %h/%h want 00/00", secCount, dedCount);
        end
        for (int i = 0; i < N; i++) begin
            logic [15:0] got;
            got = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            compared++;
            if (got !== ENC_EXP[i]) begin mismatched++; $display("[TB] FAIL enc_word%0d: got %h want %h", i, got, ENC_EXP[i]); end
        end
        repeat (3) @(posedge clk);
        #1;
        compared += 2;
        if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL enc_done_held: got %b want 1", done); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL enc_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_decode;
        int cycles, busyLow;
        loadTable(1'b0);
        runToDone(1'b1, 0, cycles, busyLow);
        compared += 3;
        if (cycles != RUN_CYC) begin mismatched++; $display("[TB] FAIL dec_latency: got %0d want %0d", cycles, RUN_CYC); end
        if (secCount !== EXP_SEC) begin mismatched++; $display("[TB] FAIL dec_sec: got %0d want %0d", secCount, EXP_SEC); end
        if (dedCount !== EXP_DED) begin mismatched++; $display("[TB] FAIL dec_ded: got %0d want %0d", dedCount, EXP_DED); end
        for (int i = 0; i < N; i++) begin
            logic [15:0] got;
            got = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            compared++;
            if (got !== DEC_EXP[i]) begin mismatched++; $display("[TB] FAIL dec_word%0d: got %h want %h", i, got, DEC_EXP[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int cycles, busyLow;
        loadTable(1'b1);
        runToDone(1'b0, 20, cycles, busyLow);
        compared += 2;
        if (cycles != RUN_CYC) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want %0d", cycles, RUN_CYC); end
        if (secCount !== 8'h00 || dedCount !== 8'h00) begin
            mismatched++; $display("[TB] FAIL b2b_counters: got %h/%h want 00/00", secCount, dedCount);
        end
        for (int i = 0; i < N; i++) begin
            logic [15:0] got;
            got = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            compared++;
            if (got !== ENC_EXP[i]) begin mismatched++; $display("[TB] FAIL b2b_word%0d: got %h want %h", i, got, ENC_EXP[i]); end
        end
    endtask

    task automatic test_reset_mid_run;
        int cycles, wrBase;
        for (int a = DST; a < DST + 2 * N; a++) loadByte(a, 8'hA5);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        while (cycles < 19) begin
            @(posedge clk); #1;
            cycles++;
        end
        compared += 3;
        if (memWrEn !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_wr_lo_en: got %b want 1", memWrEn); end
        if (memAddr !== 8'd36) begin mismatched++; $display("[TB] FAIL mid_wr_lo_addr: got %0d want 36", memAddr); end
        if (memWrData !== 8'h17) begin mismatched++; $display("[TB] FAIL mid_wr_lo_data: got %h want 17", memWrData); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
        if (memWrEn !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_wr_en: got %b want 0", memWrEn); end
        if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_addr: got %h want 00", memAddr); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_done: got %b want 0", done); end
        wrBase = wrCount;
        repeat (10) @(posedge clk);
        #1;
        compared += 6;
        if (wrCount != wrBase) begin mismatched++; $display("[TB] FAIL mid_no_writes: got %0d want %0d", wrCount, wrBase); end
        if (mem[37] !== 8'hA5) begin mismatched++; $display("[TB] FAIL mid_msg3_hi: got %h want a5", mem[37]); end
        if (mem[38] !== 8'hA5) begin mismatched++; $display("[TB] FAIL mid_msg4_lo: got %h want a5", mem[38]); end
        if (mem[34] !== 8'h0F) begin mismatched++; $display("[TB] FAIL mid_msg2_lo: got %h want 0f", mem[34]); end
        if (mem[35] !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_msg2_hi: got %h want 00", mem[35]); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_idle: got %b want 0", busy); end
    endtask

    task automatic test_zero_count;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        compared += 2;
        if (done0 !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done: got %b want 1", done0); end
        if (busy0 !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_busy: got %b want 0", busy0); end
        repeat (3) @(posedge clk);
        #1;
        compared += 4;
        if (done0 !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done_held: got %b want 1", done0); end
        if (wrCount0 != 0) begin mismatched++; $display("[TB] FAIL zero_writes: got %0d want 0", wrCount0); end
        if (memAddr0 !== 8'h00 || memWrData0 !== 8'h00) begin
            mismatched++; $display("[TB] FAIL zero_bus: got %h/%h want 00/00", memAddr0, memWrData0);
        end
        if (secCount0 !== 8'h00 || dedCount0 !== 8'h00) begin
            mismatched++; $display("[TB] FAIL zero_counters: got %h/%h want 00/00", secCount0, dedCount0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        start0   = 1'b0;
        mode     = 1'b0;
        loadEn   = 1'b0;
        loadAddr = 8'h00;
        loadData = 8'h00;
        #1;
        $display("[TB] hamming_dma directed tests");
        test_reset();
        test_encode();
        test_decode();
        test_back_to_back();
        test_reset_mid_run();
        test_zero_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
